// File: rtl/onfi_status_responder_if.sv
// ONFI command/data bus between a host controller (master) and the NAND-target
// status responder (slave).
interface onfi_status_responder_if;
  logic       onfi_cen;
  logic       onfi_cle;
  logic       onfi_ale;
  logic       onfi_wen;
  logic [7:0] onfi_dq_i;
  logic [7:0] onfi_dq_o;
  logic       onfi_dq_oe;
  logic       onfi_dqs_o;
  logic       onfi_dqs_oe;

  modport master (
    output onfi_cen, onfi_cle, onfi_ale, onfi_wen, onfi_dq_i,
    input  onfi_dq_o, onfi_dq_oe, onfi_dqs_o, onfi_dqs_oe
  );

  modport slave (
    input  onfi_cen, onfi_cle, onfi_ale, onfi_wen, onfi_dq_i,
    output onfi_dq_o, onfi_dq_oe, onfi_dqs_o, onfi_dqs_oe
  );
endinterface

// File: rtl/onfi_status_responder.sv
// NAND-target responder for ONFI Read Status: decodes 70h command strobes, waits tWHR,
// then returns the busy-masked status byte with a DQS preamble, burst and postamble.
module onfi_status_responder #(
  parameter int unsigned TWHR       = 6,
  parameter int unsigned BURST      = 4,
  parameter logic [7:0]  STATUS_CMD = 8'h70
) (
  input  logic                   onfi_clk,
  input  logic                   onfi_rstn,
  onfi_status_responder_if.slave bus,
  input  logic [7:0]             status_in,
  input  logic                   busy,
  output logic [15:0]            read_count
);
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_WHR, S_PREAMBLE, S_BURST, S_POSTAMBLE
  } state_e;

  localparam logic [5:0] WAIT_LOAD = 6'(TWHR - 1);
  localparam logic [3:0] LAST_BEAT = 4'(BURST - 1);

  state_e      state_q, state_d;
  logic [5:0]  wait_q, wait_d;
  logic [3:0]  beat_q, beat_d;
  logic [7:0]  sr_hold_q, sr_hold_d;
  logic        wen_q;
  logic [15:0] read_count_q;
  logic        read_done;
  logic [7:0]  dq_o_q, dq_o_d;
  logic        dq_oe_q, dq_oe_d;
  logic        dqs_o_q, dqs_o_d;
  logic        dqs_oe_q, dqs_oe_d;
  logic        status_strobe;
  logic [7:0]  status_masked;

  // A command latches on the WE# rising edge with CE# low, CLE high and ALE low.
  assign status_strobe = ~wen_q & bus.onfi_wen & ~bus.onfi_cen & bus.onfi_cle
                       & ~bus.onfi_ale & (bus.onfi_dq_i == STATUS_CMD);
  assign status_masked = {status_in[7], status_in[6] & ~busy, status_in[5] & ~busy,
                          status_in[4:0]};

  always_ff @(posedge onfi_clk) begin
    if (!onfi_rstn) begin
      state_q      <= S_IDLE;
      wait_q       <= '0;
      beat_q       <= '0;
      sr_hold_q    <= '0;
      wen_q        <= 1'b0;
      read_count_q <= '0;
      dq_o_q       <= '0;
      dq_oe_q      <= 1'b0;
      dqs_o_q      <= 1'b0;
      dqs_oe_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      beat_q    <= beat_d;
      sr_hold_q <= sr_hold_d;
      wen_q     <= bus.onfi_wen;
      dq_o_q    <= dq_o_d;
      dq_oe_q   <= dq_oe_d;
      dqs_o_q   <= dqs_o_d;
      dqs_oe_q  <= dqs_oe_d;
      if (read_done) begin
        read_count_q <= read_count_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    beat_d    = beat_q;
    sr_hold_d = sr_hold_q;
    read_done = 1'b0;
    // Deselecting the target abandons any read in progress without counting it.
    if (bus.onfi_cen && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (status_strobe) begin
            state_d = S_WAIT_WHR;
            wait_d  = WAIT_LOAD;
          end
        end
        S_WAIT_WHR: begin
          if (status_strobe) begin
            wait_d = WAIT_LOAD;
          end else if (wait_q == 6'd0) begin
            state_d   = S_PREAMBLE;
            sr_hold_d = status_masked;
          end else begin
            wait_d = wait_q - 6'd1;
          end
        end
        S_PREAMBLE: begin
          state_d = S_BURST;
          beat_d  = '0;
        end
        S_BURST: begin
          if (beat_q == LAST_BEAT) begin
            state_d = S_POSTAMBLE;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
        S_POSTAMBLE: begin
          state_d   = S_IDLE;
          read_done = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered pins line up with the FSM.
  always_comb begin
    dq_o_d   = '0;
    dq_oe_d  = 1'b0;
    dqs_o_d  = 1'b0;
    dqs_oe_d = 1'b0;
    case (state_d)
      S_PREAMBLE, S_POSTAMBLE: begin
        dq_oe_d  = 1'b1;
        dqs_oe_d = 1'b1;
        dq_o_d   = sr_hold_d;
      end
      S_BURST: begin
        dq_oe_d  = 1'b1;
        dqs_oe_d = 1'b1;
        dq_o_d   = sr_hold_d;
        dqs_o_d  = ~beat_d[0];
      end
      default: ;
    endcase
  end

  assign bus.onfi_dq_o   = dq_o_q;
  assign bus.onfi_dq_oe  = dq_oe_q;
  assign bus.onfi_dqs_o  = dqs_o_q;
  assign bus.onfi_dqs_oe = dqs_oe_q;
  assign read_count      = read_count_q;
endmodule

// File: tb/tb_onfi_status_responder.sv
// Bench for onfi_status_responder: table vectors, hand-written corner sequences and
// randomized traffic, all checked every cycle against a strobe-timeline reference model.
module tb_onfi_status_responder;
  localparam int TWHR  = 6;
  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  status_in;
  logic        busy;
  logic [15:0] read_count;

  onfi_status_responder_if bus();

  onfi_status_responder #(.TWHR(TWHR), .BURST(BURST), .STATUS_CMD(8'h70)) dut (
    .onfi_clk   (clk),
    .onfi_rstn  (rstn),
    .bus        (bus),
    .status_in  (status_in),
    .busy       (busy),
    .read_count (read_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, got, want, $time);
  endtask

  // Reference model: a read is described by the cycle of its accepted strobe (m_t0);
  // every output follows from the distance to that cycle.
  int          m_t  = 0;
  int          m_t0 = 0;
  bit          m_act = 1'b0;
  logic [7:0]  m_cap = 8'h00;
  logic [15:0] m_cnt = 16'h0000;
  bit          m_wenp = 1'b0;

  function automatic logic [7:0] masked(input logic [7:0] s, input logic b);
    return b ? (s & 8'h9F) : s;
  endfunction

  function automatic void model_step();
    int d;
    bit stb;
    d   = m_t - m_t0;
    stb = !m_wenp && bus.onfi_wen && !bus.onfi_cen && bus.onfi_cle && !bus.onfi_ale
          && (bus.onfi_dq_i == 8'h70);
    if (!rstn) begin
      m_act = 1'b0;
      m_cnt = 16'h0000;
    end else if (m_act && bus.onfi_cen) begin
      m_act = 1'b0;
    end else if (stb && (!m_act || d <= TWHR)) begin
      m_act = 1'b1;
      m_t0  = m_t;
    end else if (m_act && d == TWHR) begin
      m_cap = masked(status_in, busy);
    end else if (m_act && d == TWHR + 2 + BURST) begin
      m_act = 1'b0;
      m_cnt = m_cnt + 16'd1;
    end
    m_wenp = rstn ? bus.onfi_wen : 1'b0;
    m_t++;
  endfunction

  function automatic logic [10:0] model_out();
    int d;
    d = m_t - m_t0;
    if (!m_act || d <= TWHR) return 11'd0;
    if (d == TWHR + 1 || d == TWHR + 2 + BURST) return {1'b1, 1'b1, 1'b0, m_cap};
    return {1'b1, 1'b1, 1'((d - TWHR - 2) % 2 == 0), m_cap};
  endfunction

  function automatic logic [31:0] outs();
    return {21'd0, bus.onfi_dq_oe, bus.onfi_dqs_oe, bus.onfi_dqs_o, bus.onfi_dq_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("cycle_outputs", outs(), {21'd0, model_out()});
    check("cycle_read_count", {16'd0, read_count}, {16'd0, m_cnt});
  endtask

  // Drives WE# low then high with the given CLE/ALE/opcode; returns one cycle after the strobe.
  task automatic issue(input logic [7:0] op, input logic cle, input logic ale);
    bus.onfi_cen  = 1'b0;
    bus.onfi_cle  = cle;
    bus.onfi_ale  = ale;
    bus.onfi_dq_i = op;
    bus.onfi_wen  = 1'b0;
    tick();
    bus.onfi_wen  = 1'b1;
    tick();
    bus.onfi_cle  = 1'b0;
    bus.onfi_ale  = 1'b0;
    bus.onfi_dq_i = 8'h00;
  endtask

  typedef struct {
    logic [7:0] op;
    logic       cle;
    logic       ale;
    logic [7:0] st;
    logic       bsy;
    logic [7:0] dq;
    int         oe_len;
    logic [5:0] dqs_pat;
    int         cnt_inc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int         first;
    int         len;
    int         exp_cnt;
    logic [5:0] pat;
    bit         dq_ok;

    vecs[0] = '{8'h70, 1'b1, 1'b0, 8'hE0, 1'b0, 8'hE0, 6, 6'b010100, 1};
    vecs[1] = '{8'h70, 1'b1, 1'b0, 8'hE0, 1'b1, 8'h80, 6, 6'b010100, 1};
    vecs[2] = '{8'hFF, 1'b1, 1'b0, 8'hE0, 1'b0, 8'h00, 0, 6'b000000, 0};
    vecs[3] = '{8'h70, 1'b1, 1'b1, 8'hE0, 1'b0, 8'h00, 0, 6'b000000, 0};
    vecs[4] = '{8'h70, 1'b0, 1'b1, 8'hE0, 1'b0, 8'h00, 0, 6'b000000, 0};
    vecs[5] = '{8'h70, 1'b1, 1'b0, 8'hFF, 1'b1, 8'h9F, 6, 6'b010100, 1};
    vecs[6] = '{8'h70, 1'b1, 1'b0, 8'h5A, 1'b0, 8'h5A, 6, 6'b010100, 1};
    vecs[7] = '{8'h71, 1'b1, 1'b0, 8'hE0, 1'b0, 8'h00, 0, 6'b000000, 0};

    rstn = 1'b0;
    status_in = 8'h00;
    busy = 1'b0;
    bus.onfi_cen = 1'b1;
    bus.onfi_cle = 1'b0;
    bus.onfi_ale = 1'b0;
    bus.onfi_wen = 1'b1;
    bus.onfi_dq_i = 8'h00;
    repeat (2) @(negedge clk);
    tick();
    check("reset_outputs", outs(), 32'd0);
    check("reset_read_count", {16'd0, read_count}, 32'd0);
    rstn = 1'b1;
    bus.onfi_cen = 1'b0;
    exp_cnt = 0;

    for (int i = 0; i < 8; i++) begin
      status_in = vecs[i].st;
      busy = vecs[i].bsy;
      issue(vecs[i].op, vecs[i].cle, vecs[i].ale);
      first = -1;
      len = 0;
      pat = '0;
      dq_ok = 1'b1;
      for (int k = 1; k <= TWHR + BURST + 6; k++) begin
        if (bus.onfi_dq_oe) begin
          if (first < 0) first = k;
          len++;
          pat = {pat[4:0], bus.onfi_dqs_o};
          if (bus.onfi_dq_o !== vecs[i].dq) dq_ok = 1'b0;
        end
        tick();
      end
      exp_cnt += vecs[i].cnt_inc;
      check($sformatf("vec%0d_oe_start", i), 32'(first), 32'((vecs[i].oe_len > 0) ? TWHR + 1 : -1));
      check($sformatf("vec%0d_oe_len", i), 32'(len), 32'(vecs[i].oe_len));
      check($sformatf("vec%0d_dqs_pattern", i), 32'(pat), 32'(vecs[i].dqs_pat));
      check($sformatf("vec%0d_dq_value", i), 32'(dq_ok), 32'd1);
      check($sformatf("vec%0d_read_count", i), {16'd0, read_count}, 32'(exp_cnt));
    end

    // CE# high during burst beat 1 aborts without counting.
    status_in = 8'hE0;
    busy = 1'b0;
    issue(8'h70, 1'b1, 1'b0);
    repeat (TWHR + 2) tick();
    check("abort_in_burst_oe", 32'(bus.onfi_dq_oe), 32'd1);
    bus.onfi_cen = 1'b1;
    tick();
    check("abort_oe_drop", 32'({bus.onfi_dq_oe, bus.onfi_dqs_oe}), 32'd0);
    check("abort_read_count", {16'd0, read_count}, 32'(exp_cnt));
    bus.onfi_cen = 1'b0;
    repeat (8) tick();
    check("abort_no_resume", {16'd0, read_count}, 32'(exp_cnt));

    // Second 70h in WAIT_WHR cycle 3 restarts tWHR; status changes after capture are ignored.
    issue(8'h70, 1'b1, 1'b0);
    tick();
    issue(8'h70, 1'b1, 1'b0);
    repeat (TWHR - 1) tick();
    check("restart_no_early_oe", 32'(bus.onfi_dq_oe), 32'd0);
    tick();
    check("restart_preamble", outs(), {21'd0, 3'b110, 8'hE0});
    status_in = 8'h00;
    busy = 1'b1;
    tick();
    check("hold_after_capture", outs(), {21'd0, 3'b111, 8'hE0});
    repeat (BURST + 1) tick();
    exp_cnt++;
    check("restart_read_count", {16'd0, read_count}, 32'(exp_cnt));

    // Reset during burst, then a clean read.
    status_in = 8'hE0;
    busy = 1'b0;
    issue(8'h70, 1'b1, 1'b0);
    repeat (TWHR + 2) tick();
    rstn = 1'b0;
    tick();
    check("midburst_reset_outputs", outs(), 32'd0);
    check("midburst_reset_count", {16'd0, read_count}, 32'd0);
    rstn = 1'b1;
    exp_cnt = 0;
    status_in = 8'h3C;
    busy = 1'b1;
    issue(8'h70, 1'b1, 1'b0);
    repeat (TWHR) tick();
    check("post_reset_preamble", outs(), {21'd0, 3'b110, 8'h1C});
    repeat (BURST + 2) tick();
    exp_cnt++;
    check("post_reset_read_count", {16'd0, read_count}, 32'(exp_cnt));

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 2000; i++) begin
      bus.onfi_cen  = ($urandom_range(0, 39) == 0);
      bus.onfi_cle  = ($urandom_range(0, 3) != 0);
      bus.onfi_ale  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) bus.onfi_wen = ~bus.onfi_wen;
      bus.onfi_dq_i = ($urandom_range(0, 1) == 1) ? 8'h70 : 8'($urandom);
      status_in     = 8'($urandom);
      busy          = 1'($urandom_range(0, 1));
      rstn          = ($urandom_range(0, 299) != 0);
      tick();
    end
    rstn = 1'b1;
    bus.onfi_cen = 1'b0;
    bus.onfi_cle = 1'b0;
    bus.onfi_ale = 1'b0;
    bus.onfi_wen = 1'b1;
    repeat (20) tick();

    // Counter wrap: preload 65535 completed reads, then complete one more.
    dut.read_count_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    status_in = 8'hE0;
    busy = 1'b0;
    issue(8'h70, 1'b1, 1'b0);
    repeat (TWHR + BURST + 3) tick();
    check("wrap_read_count", {16'd0, read_count}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/onfi_status_responder.md
# onfi_status_responder

NAND-target-side responder for the ONFI Read Status (70h) sequence. It is the other end of the host-side `get_status` block. It decodes command cycles driven by the controller on CLE/ALE/WE#/DQ. After a latched 70h it waits tWHR, then drives the masked status byte on DQ with a DQS preamble, burst and postamble. It lives in the NAND target model used for loopback and bench testing of the controller.

## Interface
Parameters:
- `TWHR`, default 6: cycles from command latch to DQS preamble (valid range 1–63).
- `BURST`, default 4: number of data beats per status read (must be even, 2–16).
- `STATUS_CMD`, default 8'h70: opcode that triggers a status read.

Ports:
- `onfi_clk` in 1: the single clock. All logic is on its rising edge.
- `onfi_rstn` in 1: reset, synchronous, active-low.
- `onfi_cen` in 1: chip enable, active-low.
- `onfi_cle` in 1: command latch enable.
- `onfi_ale` in 1: address latch enable.
- `onfi_wen` in 1: write enable, active-low. A command is latched on its rising edge.
- `onfi_dq_i` in 8: DQ bus input from the host.
- `status_in` in 8: raw status byte from the array model.
- `busy` in 1: array busy. Masks SR[6] (RDY) and SR[5] (ARDY).
- `onfi_dq_o` out 8: DQ drive value.
- `onfi_dq_oe` out 1: DQ output enable.
- `onfi_dqs_o` out 1: DQS drive value.
- `onfi_dqs_oe` out 1: DQS output enable.
- `read_count` out 16: number of completed status bursts. Wraps modulo 2^16.

## Operation
- `wen_q` is a registered copy of `onfi_wen`.
- A command strobe occurs in a cycle where `wen_q`=0, `onfi_wen`=1, `onfi_cen`=0, `onfi_cle`=1 and `onfi_ale`=0.
  - The opcode is `onfi_dq_i` in that same cycle.
  - A strobe with CLE=ALE=1 is ignored.
  - Opcodes other than `STATUS_CMD` are ignored, with no state change.
- Masked status is {status_in[7], status_in[6]&~busy, status_in[5]&~busy, status_in[4:0]}.
  - It is captured into `sr_hold` on the cycle the FSM enters PREAMBLE.
  - It is held constant through PREAMBLE, BURST and POSTAMBLE.
- FSM states and transitions:
  - IDLE → WAIT_WHR on a 70h strobe. The wait counter is loaded with TWHR-1.
  - WAIT_WHR → PREAMBLE when the counter reaches 0. Otherwise the counter decrements.
  - PREAMBLE → BURST after 1 cycle. The beat counter is cleared.
  - BURST → POSTAMBLE after BURST cycles, one beat per cycle.
  - POSTAMBLE → IDLE after 1 cycle. `read_count` increments on this transition.
- Output values per state:
  - IDLE and WAIT_WHR: `onfi_dq_oe`=0, `onfi_dqs_oe`=0, `onfi_dq_o`=0, `onfi_dqs_o`=0.
  - PREAMBLE: both output enables=1, `onfi_dqs_o`=0, `onfi_dq_o`=`sr_hold`.
  - BURST: both output enables=1, `onfi_dq_o`=`sr_hold`, `onfi_dqs_o`=~beat[0]. Beat 0 is high, beat 1 is low, alternating.
  - POSTAMBLE: both output enables=1, `onfi_dqs_o`=0, `onfi_dq_o`=`sr_hold`.
- Boundary conditions:
  - `onfi_cen`=1 in any non-IDLE state returns the FSM to IDLE next cycle. Output enables drop that cycle. `read_count` is unchanged.
  - A new 70h strobe in WAIT_WHR reloads the counter (restart).
  - A 70h strobe in PREAMBLE, BURST or POSTAMBLE is ignored, and the burst completes.
  - CEN rise and a command strobe cannot occur in the same cycle, because a strobe requires CEN low. CEN=1 has priority.
  - Changes to `busy` or `status_in` after capture do not affect the current burst.
  - When `read_count` is at 16'hFFFF, completing a burst wraps it to 0.
- Reset: `onfi_rstn`=0 sampled at a clock edge forces IDLE and clears all counters, `sr_hold` and `wen_q`. This applies mid-burst as well.

## Timing
- All outputs are registered. Reset value of every output is 0, including `read_count`.
- Latency for a strobe detected in cycle N:
  - WAIT_WHR covers cycles N+1 … N+TWHR.
  - PREAMBLE is cycle N+TWHR+1.
  - BURST covers cycles N+TWHR+2 … N+TWHR+1+BURST.
  - POSTAMBLE is cycle N+TWHR+2+BURST.
  - IDLE, with `read_count` incremented, is visible at N+TWHR+3+BURST.
- Output enables are asserted for exactly BURST+2 consecutive cycles per uninterrupted read.
- `onfi_dq_o` never changes while `onfi_dq_oe`=1.

## Test plan
- Basic read: TWHR=6, BURST=4, status_in=8'hE0, busy=0. Pulse WE# low→high with CLE=1 and DQ=8'h70 (strobe cycle N).
  - Expect oe rising at N+7.
  - Expect DQ=8'hE0 for 6 cycles.
  - Expect DQS pattern 0,1,0,1,0,0.
  - Expect read_count=1.
- Busy mask: status_in=8'hE0, busy=1 → DQ=8'h80 throughout the burst.
- Non-status and malformed strobes: opcode 8'hFF → no output enable and read_count unchanged. 70h with ALE=1 → same result.
- Abort and restart:
  - CEN=1 in BURST beat 1 → oe=0 next cycle and read_count unchanged.
  - A second 70h at WAIT_WHR cycle 3 → preamble arrives TWHR+1 cycles after the second strobe.
- Reset mid-burst: onfi_rstn=0 for 1 cycle during BURST → all outputs 0 next cycle. The next 70h works normally.
- Wrap: preload with 65535 completed reads, issue one more → read_count=0.
